// File: rtl/posit_multiplier_seq_if.sv
// Operand/result handshake bundle for posit_multiplier_seq.
// Master drives operands and consumes the product; slave is the multiplier.
interface posit_multiplier_seq_if #(
  parameter int N = 32
);
  logic [N-1:0] IN1;
  logic [N-1:0] IN2;
  logic         IN_Valid;
  logic         IN_Ready;
  logic [N-1:0] OUT;
  logic         OUT_Valid;
  logic         OUT_Ready;

  modport master (
    output IN1, IN2, IN_Valid, OUT_Ready,
    input  IN_Ready, OUT, OUT_Valid
  );

  modport slave (
    input  IN1, IN2, IN_Valid, OUT_Ready,
    output IN_Ready, OUT, OUT_Valid
  );
endinterface

// File: rtl/posit_multiplier_seq.sv
// Sequential posit multiplier: shift-add significand product, RNE rounding.
// Define POSIT_MULT_RADIX4_EN to retire two multiplier bits per MULT cycle.
module posit_multiplier_seq #(
  parameter int N  = 32,
  parameter int ES = 4
) (
  input  logic Clock,
  input  logic nReset,
  posit_multiplier_seq_if.slave bus
);

  localparam int M  = N - ES - 2;
  localparam int PW = 2 * M;
  localparam int SW = ES + $clog2(N) + 3;
  localparam int XW = ES + PW - 1;
  localparam int YW = N + XW;
`ifdef POSIT_MULT_RADIX4_EN
  localparam int STEPS = (M + 1) / 2;
`else
  localparam int STEPS = M;
`endif
  localparam int CW = $clog2(STEPS + 1);

  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [SW-1:0] KHI = SW'(N - 2);
  localparam logic signed [SW-1:0] KLO = -SW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, DECODE, MULT, ROUND, DONE
  } state_e;

  // Returns {scale, significand-with-hidden-bit} of a non-special posit.
  function automatic logic [SW+M-1:0] dec(input logic [N-1:0] x);
    logic [N-2:0] r;
    logic [N-4:0] ef;
    logic signed [SW-1:0] k;
    logic signed [SW-1:0] sc;
    logic run;
    int m;
    r = x[N-1] ? (~x[N-2:0] + (N-1)'(1)) : x[N-2:0];
    m = 0;
    run = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (r[i] == r[N-2])) m = m + 1;
      else run = 1'b0;
    end
    k  = r[N-2] ? SW'(m - 1) : -SW'(m);
    ef = r[N-4:0] << (m - 1);
    sc = (k <<< ES) + $signed(SW'(ef >> (M - 1)));
    return {sc, 1'b1, ef[M-2:0]};
  endfunction

  state_e state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic          sign_q, sign_d;
  logic          nar_q, nar_d;
  logic          spec_q, spec_d;
  logic signed [SW-1:0] scale_q, scale_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [M-1:0]  mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out_q, out_d;
`ifdef POSIT_MULT_RADIX4_EN
  logic [PW-1:0] mcand3_q, mcand3_d;
`endif

  logic [SW+M-1:0] da, db;
  logic signed [SW-1:0] sa, sb;
  logic [M-1:0]  fa, fb;
  logic          a_zero, b_zero, a_nar, b_nar;
  logic [PW-1:0] addend;

  assign da = dec(a_q);
  assign db = dec(b_q);
  assign sa = $signed(da[SW+M-1:M]);
  assign sb = $signed(db[SW+M-1:M]);
  assign fa = da[M-1:0];
  assign fb = db[M-1:0];
  assign a_zero = (a_q == '0);
  assign b_zero = (b_q == '0);
  assign a_nar  = (a_q == NAR);
  assign b_nar  = (b_q == NAR);

  // Rounding datapath, evaluated from the finished accumulator
  logic          ovf;
  logic [PW-2:0] frac;
  logic signed [SW-1:0] ssum, kk;
  logic [XW-1:0] xw;
  logic          pos;
  logic [YW-1:0] y0, y;
  int            shi;
  logic [N-2:0]  body, body_r;
  logic          guard, sticky, up;
  logic          sat_hi, sat_lo;
  logic [N-1:0]  mag, rnd_res;

  always_comb begin
    ovf  = acc_q[PW-1];
    frac = ovf ? acc_q[PW-2:0] : {acc_q[PW-3:0], 1'b0};
    ssum = scale_q + $signed({{(SW-1){1'b0}}, ovf});
    kk   = ssum >>> ES;
    xw   = XW'(frac) | (XW'(ssum) << (PW - 1));
    pos  = ~kk[SW-1];
    y0   = {pos ? {(N-1){1'b1}} : {(N-1){1'b0}}, ~pos, xw};
    shi  = pos ? (N - 2) - int'(kk) : (N - 1) + int'(kk);
    y    = y0 << shi;
    body   = y[YW-1 -: N-1];
    guard  = y[YW-N];
    sticky = |y[YW-N-1:0];
    up     = guard & (sticky | body[0]);
    body_r = body + (N-1)'(up);
    sat_hi = (kk >= KHI);
    sat_lo = (kk <= KLO);
    if (sat_hi)      mag = {1'b0, {(N-1){1'b1}}};
    else if (sat_lo) mag = {{(N-1){1'b0}}, 1'b1};
    else             mag = {1'b0, body_r};
    rnd_res = sign_q ? -mag : mag;
    if (spec_q) rnd_res = nar_q ? NAR : '0;
  end

  always_comb begin
    addend = '0;
`ifdef POSIT_MULT_RADIX4_EN
    unique case (mplier_q[1:0])
      2'd0: addend = '0;
      2'd1: addend = mcand_q;
      2'd2: addend = mcand_q << 1;
      2'd3: addend = mcand3_q;
    endcase
`else
    if (mplier_q[0]) addend = mcand_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    nar_d    = nar_q;
    spec_d   = spec_q;
    scale_d  = scale_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
`ifdef POSIT_MULT_RADIX4_EN
    mcand3_d = mcand3_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.IN_Valid) begin
          a_d     = bus.IN1;
          b_d     = bus.IN2;
          state_d = DECODE;
        end
      end
      DECODE: begin
        nar_d    = a_nar | b_nar;
        spec_d   = a_nar | b_nar | a_zero | b_zero;
        sign_d   = a_q[N-1] ^ b_q[N-1];
        scale_d  = sa + sb;
        mcand_d  = PW'(fa);
        mplier_d = fb;
        acc_d    = '0;
        cnt_d    = CW'(STEPS);
`ifdef POSIT_MULT_RADIX4_EN
        mcand3_d = PW'(fa) + (PW'(fa) << 1);
`endif
        // specials skip MULT but still spend one cycle in ROUND
        state_d  = spec_d ? ROUND : MULT;
      end
      MULT: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q - CW'(1);
`ifdef POSIT_MULT_RADIX4_EN
        mcand_d  = mcand_q << 2;
        mcand3_d = mcand3_q << 2;
        mplier_d = mplier_q >> 2;
`else
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`endif
        if (cnt_q == CW'(1)) state_d = ROUND;
      end
      ROUND: begin
        out_d   = rnd_res;
        state_d = DONE;
      end
      DONE: begin
        if (bus.OUT_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      nar_q    <= 1'b0;
      spec_q   <= 1'b0;
      scale_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
`ifdef POSIT_MULT_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      nar_q    <= nar_d;
      spec_q   <= spec_d;
      scale_q  <= scale_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
`ifdef POSIT_MULT_RADIX4_EN
      mcand3_q <= mcand3_d;
`endif
    end
  end

  assign bus.IN_Ready  = (state_q == IDLE);
  assign bus.OUT_Valid = (state_q == DONE);
  assign bus.OUT       = out_q;

endmodule

// File: tb/tb_posit_multiplier_seq.sv
// Directed bench for posit_multiplier_seq (N=32, ES=4).
// Expected products and latencies are hand-derived constants.
module tb_posit_multiplier_seq;

  localparam int N  = 32;
  localparam int ES = 4;
  localparam int M  = N - ES - 2;
`ifdef POSIT_MULT_RADIX4_EN
  localparam int LAT = (M + 1) / 2 + 2;
`else
  localparam int LAT = M + 2;
`endif
  localparam int SLAT = 2;

  logic Clock  = 1'b0;
  logic nReset = 1'b0;

  posit_multiplier_seq_if #(.N(N)) bus ();

  posit_multiplier_seq #(.N(N), .ES(ES)) dut (
    .Clock (Clock),
    .nReset(nReset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_out,
                        input int exp_lat);
    int lat;
    @(negedge Clock);
    chk({tag, "_in_ready"}, 64'(bus.IN_Ready), 64'd1);
    bus.IN1       = a;
    bus.IN2       = b;
    bus.IN_Valid  = 1'b1;
    bus.OUT_Ready = 1'b1;
    @(posedge Clock);
    #1;
    bus.IN_Valid = 1'b0;
    bus.IN1      = ~a;
    bus.IN2      = ~b;
    lat = 0;
    while (!bus.OUT_Valid && lat < 200) begin
      @(posedge Clock);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_out"}, 64'(bus.OUT), 64'(exp_out));
    chk({tag, "_busy"}, 64'(bus.IN_Ready), 64'd0);
    @(posedge Clock);
    #1;
    chk({tag, "_vld_drop"}, 64'(bus.OUT_Valid), 64'd0);
    chk({tag, "_idle"}, 64'(bus.IN_Ready), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.IN1       = '0;
    bus.IN2       = '0;
    bus.IN_Valid  = 1'b0;
    bus.OUT_Ready = 1'b1;
    nReset        = 1'b0;
    #12;
    chk("rst_out", 64'(bus.OUT), 64'd0);
    chk("rst_out_valid", 64'(bus.OUT_Valid), 64'd0);
    chk("rst_in_ready", 64'(bus.IN_Ready), 64'd1);
    @(negedge Clock);
    nReset = 1'b1;

    run_op("one_one", 32'h40000000, 32'h40000000, 32'h40000000, LAT);
    run_op("two_two", 32'h42000000, 32'h42000000, 32'h44000000, LAT);
    run_op("neg_one", 32'hC0000000, 32'h40000000, 32'hC0000000, LAT);
    run_op("negtwo_sq", 32'hBE000000, 32'hBE000000, 32'h44000000, LAT);
    run_op("onehalf_sq", 32'h41000000, 32'h41000000, 32'h42400000, LAT);
    run_op("tie_even_dn", 32'h40001000, 32'h40001000, 32'h40002000, LAT);
    run_op("tie_even_up", 32'h41000000, 32'h40000001, 32'h41000002, LAT);
    run_op("round_up", 32'h40001000, 32'h40001001, 32'h40002002, LAT);
    run_op("nar_x", 32'h80000000, 32'hA92AA456, 32'h80000000, SLAT);
    run_op("zero_x", 32'h00000000, 32'h54AAA545, 32'h00000000, SLAT);
    run_op("nar_zero", 32'h80000000, 32'h00000000, 32'h80000000, SLAT);
    run_op("maxpos_sq", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, LAT);
    run_op("minpos_sq", 32'h00000001, 32'h00000001, 32'h00000001, LAT);

    // Backpressure: product held while the consumer stalls
    @(negedge Clock);
    bus.IN1       = 32'h42000000;
    bus.IN2       = 32'h42000000;
    bus.IN_Valid  = 1'b1;
    bus.OUT_Ready = 1'b0;
    @(posedge Clock);
    #1;
    bus.IN_Valid = 1'b0;
    lat = 0;
    while (!bus.OUT_Valid && lat < 200) begin
      @(posedge Clock);
      #1;
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'(LAT));
    for (int i = 0; i < 10; i++) begin
      bus.IN1      = 32'h7FFFFFFF;
      bus.IN2      = 32'h00000001;
      bus.IN_Valid = 1'b1;
      @(posedge Clock);
      #1;
      chk("bp_valid", 64'(bus.OUT_Valid), 64'd1);
      chk("bp_out", 64'(bus.OUT), 64'h44000000);
      chk("bp_in_ready", 64'(bus.IN_Ready), 64'd0);
    end
    bus.IN_Valid  = 1'b0;
    bus.OUT_Ready = 1'b1;
    @(posedge Clock);
    #1;
    chk("bp_release_ready", 64'(bus.IN_Ready), 64'd1);
    chk("bp_release_valid", 64'(bus.OUT_Valid), 64'd0);
    repeat (4) @(posedge Clock);
    #1;
    chk("bp_no_ghost_op", 64'(bus.IN_Ready), 64'd1);

    // Reset during the fifth MULT cycle abandons the operation
    @(negedge Clock);
    bus.IN1      = 32'h40000000;
    bus.IN2      = 32'h40000000;
    bus.IN_Valid = 1'b1;
    @(posedge Clock);
    #1;
    bus.IN_Valid = 1'b0;
    repeat (5) @(posedge Clock);
    #2;
    nReset = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(bus.OUT_Valid), 64'd0);
    chk("mrst_out", 64'(bus.OUT), 64'd0);
    chk("mrst_in_ready", 64'(bus.IN_Ready), 64'd1);
    @(negedge Clock);
    nReset = 1'b1;
    lat = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge Clock);
      #1;
      if (bus.OUT_Valid) lat++;
    end
    chk("mrst_no_product", 64'(lat), 64'd0);
    run_op("post_rst", 32'h40000000, 32'h40000000, 32'h40000000, LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
